framebuffer: RTL and testbench

//  Pixel sink and store at the receiving end of the draw engines' pixel-write

---
 rtl/framebuffer_if.sv | 30 +++
 rtl/framebuffer.sv | 113 +++++++++++
 tb/tb_framebuffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_if.sv
// Pixel-write, clear and read-back signals between the draw/scan-out side
// (master) and the framebuffer store (slave).
interface framebuffer_if #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 7
);
    logic               writeEn;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic [7:0]         colour;
    logic               clear;
    logic [7:0]         clearColour;
    logic               busy;
    logic               dropped;
    logic               rdReq;
    logic [X_WIDTH-1:0] rdX;
    logic [Y_WIDTH-1:0] rdY;
    logic               rdValid;
    logic [7:0]         rdColour;

    modport master (
        output writeEn, x, y, colour, clear, clearColour, rdReq, rdX, rdY,
        input  busy, dropped, rdValid, rdColour
    );

    modport slave (
        input  writeEn, x, y, colour, clear, clearColour, rdReq, rdX, rdY,
        output busy, dropped, rdValid, rdColour
    );
endinterface

// File: rtl/framebuffer.sv
// X_MAX x Y_MAX x 8-bit pixel store: one draw write per cycle, full-screen clear,
// 1-cycle read-first read port. Optional FRAMEBUFFER_TRANSPARENT_EN skips colour 8'hE3.
module framebuffer #(
    parameter int X_WIDTH    = 8,
    parameter int X_MAX      = 160,
    parameter int Y_WIDTH    = 7,
    parameter int Y_MAX      = 120,
    parameter int ADDR_WIDTH = 15
) (
    input logic          clk,
    input logic          reset,
    framebuffer_if.slave fb
);
    localparam int                    NPIX = X_MAX * Y_MAX;
    localparam logic [X_WIDTH:0]      XLIM = (X_WIDTH + 1)'(X_MAX);
    localparam logic [Y_WIDTH:0]      YLIM = (Y_WIDTH + 1)'(Y_MAX);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NPIX - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [7:0]            fill_q;
    logic                  busy_q, dropped_q;
    logic                  rd_valid_q;
    logic [7:0]            rd_data_q, rd_data_d;
    logic [7:0]            mem_q [NPIX];

    logic                  wr_in_range, rd_in_range;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic                  st_en_d;
    logic [ADDR_WIDTH-1:0] st_addr_d;
    logic [7:0]            st_data_d;

    assign wr_in_range = ({1'b0, fb.x} < XLIM) && ({1'b0, fb.y} < YLIM);
    assign rd_in_range = ({1'b0, fb.rdX} < XLIM) && ({1'b0, fb.rdY} < YLIM);
    assign wr_addr = ADDR_WIDTH'(fb.y) * ADDR_WIDTH'(X_MAX) + ADDR_WIDTH'(fb.x);
    assign rd_addr = ADDR_WIDTH'(fb.rdY) * ADDR_WIDTH'(X_MAX) + ADDR_WIDTH'(fb.rdX);

    // Single store write port: clear sweep has priority, draw writes only in IDLE.
    always_comb begin
        st_en_d   = 1'b0;
        st_addr_d = wr_addr;
        st_data_d = fb.colour;
        if (state_q == CLEAR) begin
            st_en_d   = 1'b1;
            st_addr_d = cnt_q;
            st_data_d = fill_q;
        end else if (fb.writeEn && wr_in_range) begin
`ifdef FRAMEBUFFER_TRANSPARENT_EN
            st_en_d = (fb.colour != 8'hE3);
`else
            st_en_d = 1'b1;
`endif
        end
    end

    // Store has no reset; a reset cycle simply blocks the write so an aborted
    // clear leaves the not-yet-swept pixels intact.
    always_ff @(posedge clk) begin
        if (!reset && st_en_d)
            mem_q[st_addr_d] <= st_data_d;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (fb.rdReq)
            rd_data_d = rd_in_range ? mem_q[rd_addr] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            rd_valid_q <= fb.rdReq;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fill_q    <= 8'h00;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= fb.writeEn && ((state_q == CLEAR) || !wr_in_range);
            case (state_q)
                IDLE: if (fb.clear) begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    fill_q  <= fb.clearColour;
                    busy_q  <= 1'b1;
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fb.busy     = busy_q;
    assign fb.dropped  = dropped_q;
    assign fb.rdValid  = rd_valid_q;
    assign fb.rdColour = rd_data_q;
endmodule

// File: tb/tb_framebuffer.sv
// Directed bench for framebuffer: pixel-array model checked every cycle plus
// literal expectations for writes, drops, clears, read-first and reset abort.
module tb_framebuffer;
    localparam int NPIX = 160 * 120;
`ifdef FRAMEBUFFER_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    framebuffer_if #(.X_WIDTH(8), .Y_WIDTH(7)) fb();
    framebuffer dut (.clk(clk), .reset(reset), .fb(fb));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: screen as a plain pixel array ----------------
    logic [7:0] mmem [NPIX];
    bit         mknown [NPIX];
    bit         clearing = 0;
    int         clr_idx = 0;
    logic [7:0] fill = 8'h00;
    logic       e_rdv = 0, e_drop = 0, e_busy = 0;
    logic [7:0] e_rdc = 8'h00;
    bit         e_rdc_known = 1;
    bit         started = 0;

    always @(posedge clk) begin : model
        int a;
        started = 1;
        if (reset) begin
            e_rdv = 0; e_rdc = 0; e_rdc_known = 1; e_drop = 0; e_busy = 0;
            clearing = 0;
        end else begin
            if (fb.rdReq) begin
                e_rdv = 1;
                if (fb.rdX < 160 && fb.rdY < 120) begin
                    a = int'(fb.rdY) * 160 + int'(fb.rdX);
                    e_rdc = mmem[a];
                    e_rdc_known = mknown[a];
                end else begin
                    e_rdc = 0;
                    e_rdc_known = 1;
                end
            end else e_rdv = 0;
            e_drop = 0;
            if (clearing) begin
                mmem[clr_idx] = fill;
                mknown[clr_idx] = 1;
                clr_idx++;
                if (clr_idx == NPIX) clearing = 0;
                e_drop = fb.writeEn;
            end else begin
                if (fb.writeEn) begin
                    if (fb.x < 160 && fb.y < 120) begin
                        if (!(TRANSP && fb.colour == 8'hE3)) begin
                            a = int'(fb.y) * 160 + int'(fb.x);
                            mmem[a] = fb.colour;
                            mknown[a] = 1;
                        end
                    end else e_drop = 1;
                end
                if (fb.clear) begin
                    clearing = 1;
                    clr_idx = 0;
                    fill = fb.clearColour;
                end
            end
            e_busy = clearing;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_busy", 32'(fb.busy), 32'(e_busy));
            chk("m_dropped", 32'(fb.dropped), 32'(e_drop));
            chk("m_rdValid", 32'(fb.rdValid), 32'(e_rdv));
            if (e_rdc_known) chk("m_rdColour", 32'(fb.rdColour), 32'(e_rdc));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int x, input int y, input logic [7:0] c);
        fb.writeEn = 1; fb.x = 8'(x); fb.y = 7'(y); fb.colour = c;
        @(negedge clk);
        fb.writeEn = 0;
    endtask

    task automatic rd_expect(input string name, input int x, input int y, input logic [7:0] exp);
        fb.rdReq = 1; fb.rdX = 8'(x); fb.rdY = 7'(y);
        @(negedge clk);
        fb.rdReq = 0;
        chk({name, "_valid"}, 32'(fb.rdValid), 32'd1);
        chk(name, 32'(fb.rdColour), 32'(exp));
    endtask

    task automatic start_clear(input logic [7:0] c);
        fb.clear = 1; fb.clearColour = c;
        @(negedge clk);
        fb.clear = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (fb.busy && n < 25000) begin
            @(negedge clk);
            n++;
        end
        if (fb.busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1;
        fb.writeEn = 0; fb.x = 0; fb.y = 0; fb.colour = 0;
        fb.clear = 0; fb.clearColour = 0;
        fb.rdReq = 0; fb.rdX = 0; fb.rdY = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(fb.busy), 32'd0);
        chk("rst_dropped", 32'(fb.dropped), 32'd0);
        chk("rst_rdValid", 32'(fb.rdValid), 32'd0);
        chk("rst_rdColour", 32'(fb.rdColour), 32'd0);
        reset = 0;
        @(negedge clk);

        // 1: basic write then read
        wr(3, 5, 8'h1C);
        rd_expect("t1_read", 3, 5, 8'h1C);
        @(negedge clk);
        chk("t1_rdValid_low", 32'(fb.rdValid), 32'd0);
        chk("t1_rdColour_hold", 32'(fb.rdColour), 32'h1C);

        // 2: out-of-range writes are dropped for exactly one cycle
        wr(159, 0, 8'h21);
        wr(0, 119, 8'h22);
        wr(160, 0, 8'h99);
        chk("t2_drop_x", 32'(fb.dropped), 32'd1);
        @(negedge clk);
        chk("t2_drop_x_end", 32'(fb.dropped), 32'd0);
        wr(0, 120, 8'h98);
        chk("t2_drop_y", 32'(fb.dropped), 32'd1);
        @(negedge clk);
        chk("t2_drop_y_end", 32'(fb.dropped), 32'd0);
        rd_expect("t2_read_159_0", 159, 0, 8'h21);
        rd_expect("t2_read_0_119", 0, 119, 8'h22);
        rd_expect("t2_read_oob", 200, 3, 8'h00);

        // 3: full clear, busy width
        start_clear(8'hFF);
        n = 0;
        while (fb.busy && n < 25000) begin
            n++;
            @(negedge clk);
        end
        chk("t3_busy_cycles", 32'(n), 32'd19200);
        rd_expect("t3_read_0_0", 0, 0, 8'hFF);
        rd_expect("t3_read_159_119", 159, 119, 8'hFF);
        rd_expect("t3_read_80_60", 80, 60, 8'hFF);

        // 4: same-cycle write+clear, then a write during clear
        fb.writeEn = 1; fb.x = 20; fb.y = 20; fb.colour = 8'h66;
        start_clear(8'h0F);
        fb.writeEn = 0;
        chk("t4_busy_rise", 32'(fb.busy), 32'd1);
        repeat (3) @(negedge clk);
        wr(10, 10, 8'h77);
        chk("t4_drop_in_clear", 32'(fb.dropped), 32'd1);
        wait_idle("t4_clear");
        rd_expect("t4_read_10_10", 10, 10, 8'h0F);
        rd_expect("t4_read_20_20", 20, 20, 8'h0F);

        // 5: read-first on same-cycle read/write
        wr(7, 7, 8'h55);
        fb.rdReq = 1; fb.rdX = 7; fb.rdY = 7;
        wr(7, 7, 8'h03);
        fb.rdReq = 0;
        chk("t5_read_old", 32'(fb.rdColour), 32'h55);
        rd_expect("t5_read_new", 7, 7, 8'h03);

        // 6: reset aborts clear at sweep address 100
        wr(99, 0, 8'h24);
        wr(100, 0, 8'h42);
        start_clear(8'hA5);
        repeat (100) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("t6_busy_after_reset", 32'(fb.busy), 32'd0);
        rd_expect("t6_read_0", 0, 0, 8'hA5);
        rd_expect("t6_read_99", 99, 0, 8'hA5);
        rd_expect("t6_read_100", 100, 0, 8'h42);
        rd_expect("t6_read_101", 101, 0, 8'h0F);

        // transparent colour handling
        wr(5, 5, 8'h10);
        wr(5, 5, 8'hE3);
        chk("t6_transp_nodrop", 32'(fb.dropped), 32'd0);
        rd_expect("t6_transp_read", 5, 5, TRANSP ? 8'h10 : 8'hE3);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
